ctrl_callret_seq: RTL
=====================

CTRL_CALLRET_SEQ -- requirements
Module: ctrl_callret_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is asynchronous and active-low: clear on 0, run on 1.
REQ-003 SHALL have port req_valid, input, 1, a call/return request is offered.
REQ-004 SHALL have port req_type, input, 1, 0 = call (JMP, JMP{LT,GT,EQ,C} taken), 1 = return (JR RA).
REQ-005 SHALL have port req_link, input, 10, return address to save on a call; ignored on a return.
REQ-006 SHALL have port req_ready, output, 1, request accepted this cycle when high with req_valid.
REQ-007 SHALL have port stk_push, output, 1, push strobe to the call/return stack.
REQ-008 SHALL have port stk_pop, output, 1, pop strobe to the call/return stack.
REQ-009 SHALL have port stk_push_addr, output, 10, address to push; equals req_link.
REQ-010 SHALL have port stk_ret_addr, input, 10, registered top-of-stack from the stack.
REQ-011 SHALL have port redir_valid, output, 1, one-cycle PC redirect pulse for a return.
REQ-012 SHALL have port redir_target, output, 10, return target, valid while redir_valid is high.
REQ-013 SHALL have port depth, output, 3, number of live stack entries, range 0..7.
REQ-014 SHALL have ports err_ovf and err_unf, outputs, 1 each, sticky overflow and underflow flags.
REQ-015 SHALL have port err_clr, input, 1, synchronous clear of both sticky flags.

Function
REQ-016 SHALL implement FSM states IDLE and SETTLE.
REQ-017 SHALL drive req_ready = 1 only in IDLE; a handshake is req_valid & req_ready.
REQ-018 SHALL, on a call handshake in cycle n with depth < 7, assert stk_push combinationally in cycle n, increment depth at the edge, and enter SETTLE.
REQ-019 SHALL, on a return handshake in cycle n with depth > 0, assert stk_pop in cycle n, capture stk_ret_addr into redir_target, pulse redir_valid in cycle n+1, decrement depth, and enter SETTLE.
REQ-020 SHALL remain in SETTLE for exactly one cycle with req_ready = 0, then return to IDLE.
- Reason: stk_ret_addr lags a push or pop by two edges.
- Result: sustained throughput is one request per 2 cycles.
REQ-021 SHALL, on a return with depth = 0, not assert stk_pop, redirect to 10'h000, set err_unf, and enter SETTLE.
REQ-022 SHALL handle a call with depth = 7 per REQ-032/REQ-033, never assert stk_push, and keep depth at 7.
REQ-023 SHALL never assert stk_push and stk_pop in the same cycle; each strobe is at most one cycle wide.
REQ-024 SHALL hold stk_push, stk_pop and redir_valid at 0 when no handshake occurs.
REQ-025 SHALL, when err_clr and a new error event coincide, leave the flag set (set wins).

Reset
REQ-026 SHALL, while reset = 0, force:
- state = IDLE, depth = 0;
- redir_valid = 0, redir_target = 10'h000;
- err_ovf = 0, err_unf = 0.
REQ-027 SHALL keep stk_push and stk_pop at 0 while reset = 0, including reset asserted mid-SETTLE.
REQ-028 SHALL drop any captured redirect if reset is asserted in the cycle before its pulse.
REQ-029 SHALL assert req_ready in the first cycle after reset deasserts.
REQ-030 SHALL require the system to reset the stack in the same window so depth and the stack pointer agree.

Configuration
REQ-031 SHALL use macro CALLRET_OVF_TRAP_EN.
REQ-032 SHALL, when CALLRET_OVF_TRAP_EN is defined, on a call with depth = 7:
- not complete the handshake (req_ready = 0) and set err_ovf;
- hold req_ready low until a return handshake lowers depth or reset.
- Returns are still accepted while the call is blocked.
REQ-033 SHALL, when CALLRET_OVF_TRAP_EN is undefined, on a call with depth = 7:
- accept the call, drop the push silently, set err_ovf, and enter SETTLE.

Verification
REQ-034 Call then return: call link 10'h05A at cycle 0 -> stk_push at cycle 0, depth 1, req_ready 0 at cycle 1; return at cycle 2 -> stk_pop at cycle 2, redir_valid with target 10'h05A at cycle 3, depth 0.
REQ-035 Nested calls: 3 back-to-back calls with links 10'h010, 10'h020, 10'h030, then 3 returns -> targets 10'h030, 10'h020, 10'h010 in order; accepted requests are spaced 2 cycles apart.
REQ-036 Underflow: return at depth 0 -> no stk_pop, redir_target 10'h000, err_unf = 1; err_clr pulse -> err_unf = 0.
REQ-037 Overflow: 8 calls.
- Without CALLRET_OVF_TRAP_EN: 8th accepted with no stk_push, err_ovf = 1, depth stays 7.
- With CALLRET_OVF_TRAP_EN: 8th stalls with req_ready = 0 until a return, then completes.
REQ-038 Reset mid-operation: reset = 0 during SETTLE after a return -> no redir_valid pulse, depth 0, req_ready 1 in the first cycle after release.

Source files
------------

// File: rtl/ctrl_callret_seq_if.sv
// Call/return sequencer bus: request handshake, stack strobes, redirect and error status.
interface ctrl_callret_seq_if;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 3;

  logic          req_valid;
  logic          req_type;
  logic [AW-1:0] req_link;
  logic          req_ready;
  logic          stk_push;
  logic          stk_pop;
  logic [AW-1:0] stk_push_addr;
  logic [AW-1:0] stk_ret_addr;
  logic          redir_valid;
  logic [AW-1:0] redir_target;
  logic [DW-1:0] depth;
  logic          err_ovf;
  logic          err_unf;
  logic          err_clr;

  modport master (
    output req_valid, req_type, req_link, stk_ret_addr, err_clr,
    input  req_ready, stk_push, stk_pop, stk_push_addr,
           redir_valid, redir_target, depth, err_ovf, err_unf
  );

  modport slave (
    input  req_valid, req_type, req_link, stk_ret_addr, err_clr,
    output req_ready, stk_push, stk_pop, stk_push_addr,
           redir_valid, redir_target, depth, err_ovf, err_unf
  );
endinterface

// File: rtl/ctrl_callret_seq.sv
// Call/return sequencer: drives a 7-deep return stack, issues return redirects, tracks depth and errors.
// Optional macro CALLRET_OVF_TRAP_EN stalls a call at full depth instead of dropping its push.
module ctrl_callret_seq (
  input  logic                clk,
  input  logic                reset,
  ctrl_callret_seq_if.slave   bus
);
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 3;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(7);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SETTLE = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [DW-1:0] r_depth;
  logic          r_redir_valid;
  logic [AW-1:0] r_redir_target;
  logic          r_err_ovf;
  logic          r_err_unf;

  logic w_full, w_empty, w_idle;
  logic w_call_req, w_ret_req, w_block;
  logic w_ready, w_hs_call, w_hs_ret;
  logic w_ovf_evt, w_unf_evt;

  assign w_full     = (r_depth == DEPTH_MAX);
  assign w_empty    = (r_depth == '0);
  assign w_idle     = reset & (r_state == IDLE);
  assign w_call_req = bus.req_valid & ~bus.req_type;
  assign w_ret_req  = bus.req_valid &  bus.req_type;

`ifdef CALLRET_OVF_TRAP_EN
  // A call at full depth is refused but still flags overflow; returns keep flowing.
  assign w_block   = w_call_req & w_full;
  assign w_ovf_evt = w_idle & w_call_req & w_full;
`else
  assign w_block   = 1'b0;
  assign w_ovf_evt = w_hs_call & w_full;
`endif

  assign w_ready   = w_idle & ~w_block;
  assign w_hs_call = w_call_req & w_ready;
  assign w_hs_ret  = w_ret_req  & w_ready;
  assign w_unf_evt = w_hs_ret & w_empty;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: every accepted request costs one SETTLE cycle for the stack to catch up
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs_call | w_hs_ret) w_state_nxt = SETTLE;
      SETTLE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Depth, redirect and sticky error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth        <= '0;
      r_redir_valid  <= 1'b0;
      r_redir_target <= '0;
      r_err_ovf      <= 1'b0;
      r_err_unf      <= 1'b0;
    end else begin
      if (w_hs_call && !w_full)      r_depth <= r_depth + DW'(1);
      else if (w_hs_ret && !w_empty) r_depth <= r_depth - DW'(1);

      r_redir_valid <= w_hs_ret;
      if (w_hs_ret) r_redir_target <= w_empty ? '0 : bus.stk_ret_addr;

      if (w_ovf_evt)        r_err_ovf <= 1'b1;
      else if (bus.err_clr) r_err_ovf <= 1'b0;

      if (w_unf_evt)        r_err_unf <= 1'b1;
      else if (bus.err_clr) r_err_unf <= 1'b0;
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.stk_push      = w_hs_call & ~w_full;
  assign bus.stk_pop       = w_hs_ret  & ~w_empty;
  assign bus.stk_push_addr = bus.req_link;
  assign bus.redir_valid   = r_redir_valid;
  assign bus.redir_target  = r_redir_target;
  assign bus.depth         = r_depth;
  assign bus.err_ovf       = r_err_ovf;
  assign bus.err_unf       = r_err_unf;
endmodule
